// File: rtl/vga_pkg.sv
// Shared geometry defaults, counter widths and helpers for the VGA window compositor.
package vga_pkg;

  // Default screen and window geometry.
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_WIN_X0     = 120;
  localparam int DEF_WIN_Y0     = 40;
  localparam int DEF_WIN_W      = 400;
  localparam int DEF_WIN_H      = 400;

  // Colour index and cursor defaults.
  localparam int DEF_IDX_W      = 8;
  localparam int DEF_TRANSP_IDX = 0;
  localparam int DEF_CUR_SIZE   = 8;
  localparam int DEF_CUR_IDX    = 255;
  localparam int DEF_CUR_STEP   = 4;

  // Pixel coordinate widths; the X variants carry one spare bit so that
  // "position + size" comparisons never overflow.
  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  localparam int CX_W  = COL_W + 1;
  localparam int RX_W  = ROW_W + 1;

  // Per-pixel control bits that travel down the pipeline beside the index.
  typedef struct packed {
    logic blank_n;  // active video and frame already aligned
    logic hs;
    logic vs;
    logic win_vis;  // inside the window with the window layer enabled
    logic hit;      // covered by the cursor square
  } pix_ctl_t;

  // Smallest address width able to hold 'depth' distinct addresses.
  function automatic int calc_aw(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/vga_cursor.sv
// Cursor square: position register, once-per-frame move on the iVS falling
// edge with clamping to the window, and the per-pixel hit test.
module vga_cursor
  import vga_pkg::*;
#(
  parameter int WIN_X0   = DEF_WIN_X0,
  parameter int WIN_Y0   = DEF_WIN_Y0,
  parameter int WIN_W    = DEF_WIN_W,
  parameter int WIN_H    = DEF_WIN_H,
  parameter int CUR_SIZE = DEF_CUR_SIZE,
  parameter int CUR_STEP = DEF_CUR_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             en,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             hit
);

  // Legal top-left range keeps the whole square inside the window.
  localparam logic [CX_W-1:0] COL_MIN  = CX_W'(WIN_X0);
  localparam logic [CX_W-1:0] COL_MAX  = CX_W'(WIN_X0 + WIN_W - CUR_SIZE);
  localparam logic [CX_W-1:0] COL_STEP = CX_W'(CUR_STEP);
  localparam logic [CX_W-1:0] COL_SIZE = CX_W'(CUR_SIZE);
  localparam logic [RX_W-1:0] ROW_MIN  = RX_W'(WIN_Y0);
  localparam logic [RX_W-1:0] ROW_MAX  = RX_W'(WIN_Y0 + WIN_H - CUR_SIZE);
  localparam logic [RX_W-1:0] ROW_STEP = RX_W'(CUR_STEP);
  localparam logic [RX_W-1:0] ROW_SIZE = RX_W'(CUR_SIZE);

  // Reset position centres the square in the window.
  localparam logic [COL_W-1:0] COL_HOME = COL_W'(WIN_X0 + ((WIN_W - CUR_SIZE) >> 1));
  localparam logic [ROW_W-1:0] ROW_HOME = ROW_W'(WIN_Y0 + ((WIN_H - CUR_SIZE) >> 1));

  logic            vs_q;
  logic            vs_fall;
  logic [CX_W-1:0] col_x;
  logic [CX_W-1:0] col_nxt;
  logic [RX_W-1:0] row_x;
  logic [RX_W-1:0] row_nxt;

  assign vs_fall = vs_q & ~vs;

  // Candidate next position; opposing directions cancel, edges saturate.
  always_comb begin
    col_x   = {1'b0, cursor_col};
    row_x   = {1'b0, cursor_row};
    col_nxt = col_x;
    row_nxt = row_x;
    if (right && !left) begin
      col_nxt = (col_x + COL_STEP > COL_MAX) ? COL_MAX : col_x + COL_STEP;
    end else if (left && !right) begin
      col_nxt = (col_x < COL_MIN + COL_STEP) ? COL_MIN : col_x - COL_STEP;
    end
    if (down && !up) begin
      row_nxt = (row_x + ROW_STEP > ROW_MAX) ? ROW_MAX : row_x + ROW_STEP;
    end else if (up && !down) begin
      row_nxt = (row_x < ROW_MIN + ROW_STEP) ? ROW_MIN : row_x - ROW_STEP;
    end
  end

  // Position register, updated only on the cycle iVS falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      cursor_col <= COL_HOME;
      cursor_row <= ROW_HOME;
    end else begin
      vs_q <= vs;
      if (vs_fall) begin
        cursor_col <= col_nxt[COL_W-1:0];
        cursor_row <= row_nxt[ROW_W-1:0];
      end
    end
  end

  // Hit test for the current pixel, only where the window layer is visible.
  assign hit = en &&
               ({1'b0, col} >= col_x) && ({1'b0, col} < col_x + COL_SIZE) &&
               ({1'b0, row} >= row_x) && ({1'b0, row} < row_x + ROW_SIZE);

endmodule

// File: rtl/vga_window_compositor.sv
// Composites background, a ROM-backed image window and a movable cursor into
// one palette index stream, three cycles behind the sync-generator inputs.
module vga_window_compositor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int WIN_X0     = DEF_WIN_X0,
  parameter int WIN_Y0     = DEF_WIN_Y0,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int WIN_H      = DEF_WIN_H,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int TRANSP_IDX = DEF_TRANSP_IDX,
  parameter int CUR_SIZE   = DEF_CUR_SIZE,
  parameter int CUR_IDX    = DEF_CUR_IDX,
  parameter int CUR_STEP   = DEF_CUR_STEP,
  localparam int AW        = calc_aw(WIN_W * WIN_H)
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             iBLANK_n,
  input  logic             iHS,
  input  logic             iVS,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             win_en,
  input  logic [IDX_W-1:0] bg_index,
  output logic [AW-1:0]    win_addr,
  input  logic [IDX_W-1:0] win_q,
  output logic [IDX_W-1:0] oIndex,
  output logic             oBLANK_n,
  output logic             oHS,
  output logic             oVS,
  output logic [8:0]       cursor_row,
  output logic [9:0]       cursor_col
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_ACTIVE - 1);
  localparam logic [CX_W-1:0]  WX_LO     = CX_W'(WIN_X0);
  localparam logic [CX_W-1:0]  WX_HI     = CX_W'(WIN_X0 + WIN_W);
  localparam logic [RX_W-1:0]  WY_LO     = RX_W'(WIN_Y0);
  localparam logic [RX_W-1:0]  WY_HI     = RX_W'(WIN_Y0 + WIN_H);
  localparam logic [AW-1:0]    ADDR_LAST = AW'(WIN_W * WIN_H - 1);
  localparam logic [IDX_W-1:0] IDX_TRANSP = IDX_W'(TRANSP_IDX);
  localparam logic [IDX_W-1:0] IDX_CURSOR = IDX_W'(CUR_IDX);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             synced;
  logic             pix_valid;
  logic             in_win;
  logic             win_vis;
  logic             cur_hit;
  logic [AW-1:0]    addr_cnt;
  pix_ctl_t         s0_ctl;
  pix_ctl_t         s1_ctl;
  pix_ctl_t         s2_ctl;
  logic [IDX_W-1:0] s1_bg;
  logic [IDX_W-1:0] s2_bg;

  // After reset nothing is shown until an iVS low realigns the counters,
  // so a frame interrupted by reset is blanked rather than drawn misplaced.
  assign pix_valid = iBLANK_n & synced;

  assign in_win = pix_valid &&
                  ({1'b0, col} >= WX_LO) && ({1'b0, col} < WX_HI) &&
                  ({1'b0, row} >= WY_LO) && ({1'b0, row} < WY_HI);

  // The cursor is part of the window layer, so it disappears with win_en.
  assign win_vis = in_win & win_en;

  assign s0_ctl = '{blank_n: pix_valid, hs: iHS, vs: iVS, win_vis: win_vis, hit: cur_hit};

  // Frame alignment flag: set by the first iVS low after reset.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      synced <= 1'b0;
    end else if (!iVS) begin
      synced <= 1'b1;
    end
  end

  // Raster position of the current pixel; cleared throughout vertical sync.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n || !iVS) begin
      col <= '0;
      row <= '0;
    end else if (iBLANK_n) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window address: addr_cnt is the address of the next window pixel, and
  // win_addr registers it for the ROM so data returns two cycles after the pixel.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n || !iVS) begin
      addr_cnt <= '0;
      win_addr <= '0;
    end else if (in_win) begin
      win_addr <= addr_cnt;
      addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
    end
  end

  // Two delay stages that line control bits and background up with win_q.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      s1_ctl <= '0;
      s2_ctl <= '0;
      s1_bg  <= '0;
      s2_bg  <= '0;
    end else begin
      s1_ctl <= s0_ctl;
      s2_ctl <= s1_ctl;
      s1_bg  <= bg_index;
      s2_bg  <= s1_bg;
    end
  end

  // Output stage: layer priority blank > cursor > opaque window > background.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      oIndex   <= '0;
      oBLANK_n <= 1'b0;
      oHS      <= 1'b0;
      oVS      <= 1'b0;
    end else begin
      oBLANK_n <= s2_ctl.blank_n;
      oHS      <= s2_ctl.hs;
      oVS      <= s2_ctl.vs;
      if (!s2_ctl.blank_n) begin
        oIndex <= '0;
      end else if (s2_ctl.hit) begin
        oIndex <= IDX_CURSOR;
      end else if (s2_ctl.win_vis && (win_q != IDX_TRANSP)) begin
        oIndex <= win_q;
      end else begin
        oIndex <= s2_bg;
      end
    end
  end

  vga_cursor #(
    .WIN_X0   (WIN_X0),
    .WIN_Y0   (WIN_Y0),
    .WIN_W    (WIN_W),
    .WIN_H    (WIN_H),
    .CUR_SIZE (CUR_SIZE),
    .CUR_STEP (CUR_STEP)
  ) u_cursor (
    .clk        (iVGA_CLK),
    .rst_n      (iRST_n),
    .vs         (iVS),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .en         (win_vis),
    .col        (col),
    .row        (row),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .hit        (cur_hit)
  );

endmodule

// File: tb/tb_vga_window_compositor.sv
// Directed bench for vga_window_compositor on a scaled-down raster:
// 16x12 active, window 8x6 at (x=4,y=2), 2x2 cursor stepping 2 pixels.
// Each line is 16 active + 4 blank cycles; each frame is one vsync line,
// one blank line, then 12 active lines.
module tb_vga_window_compositor;

  localparam int H_ACT  = 16;
  localparam int V_ACT  = 12;
  localparam int H_BLK  = 4;
  localparam int WX0    = 4;
  localparam int WY0    = 2;
  localparam int WW     = 8;
  localparam int WH     = 6;
  localparam int CSZ    = 2;
  localparam int CSTEP  = 2;
  localparam int AW     = vga_pkg::calc_aw(WW * WH);

  logic          clk;
  logic          iRST_n;
  logic          iBLANK_n;
  logic          iHS;
  logic          iVS;
  logic          up;
  logic          down;
  logic          left;
  logic          right;
  logic          win_en;
  logic [7:0]    bg_index;
  logic [AW-1:0] win_addr;
  logic [7:0]    win_q;
  logic [7:0]    oIndex;
  logic          oBLANK_n;
  logic          oHS;
  logic          oVS;
  logic [8:0]    cursor_row;
  logic [9:0]    cursor_col;

  int            total;
  int            bad;
  logic [10:0]   exp_q[$];
  int            pix_q[$];
  logic          synced_m;
  logic          rom_transp;
  logic [7:0]    bg_val;
  int            cur_r;
  int            cur_c;

  vga_window_compositor #(
    .H_ACTIVE   (H_ACT),
    .V_ACTIVE   (V_ACT),
    .WIN_X0     (WX0),
    .WIN_Y0     (WY0),
    .WIN_W      (WW),
    .WIN_H      (WH),
    .IDX_W      (8),
    .TRANSP_IDX (0),
    .CUR_SIZE   (CSZ),
    .CUR_IDX    (255),
    .CUR_STEP   (CSTEP)
  ) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (iRST_n),
    .iBLANK_n   (iBLANK_n),
    .iHS        (iHS),
    .iVS        (iVS),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .win_en     (win_en),
    .bg_index   (bg_index),
    .win_addr   (win_addr),
    .win_q      (win_q),
    .oIndex     (oIndex),
    .oBLANK_n   (oBLANK_n),
    .oHS        (oHS),
    .oVS        (oVS),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window ROM: one-cycle registered read, data = low address byte, or all transparent.
  always @(posedge clk) begin
    win_q <= rom_transp ? 8'h00 : 8'(win_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One pixel cycle: drive inputs, queue the expected output, advance, check.
  task automatic drive_pix(input logic act, input logic hs, input logic vs, input int x, input int y);
    logic       e_blank;
    logic       in_w;
    logic       hit;
    int         a;
    int         tag_pix;
    logic [7:0] q;
    logic [7:0] e_idx;
    logic [10:0] e;
    iBLANK_n = act;
    iHS      = hs;
    iVS      = vs;
    bg_index = bg_val;
    e_blank  = act & synced_m;
    in_w     = e_blank && (x >= WX0) && (x < WX0 + WW) && (y >= WY0) && (y < WY0 + WH);
    a        = in_w ? (y - WY0) * WW + (x - WX0) : 0;
    q        = rom_transp ? 8'h00 : 8'(a);
    hit      = in_w && win_en && (x >= cur_c) && (x < cur_c + CSZ) && (y >= cur_r) && (y < cur_r + CSZ);
    if (!e_blank)                      e_idx = 8'h00;
    else if (hit)                      e_idx = 8'hFF;
    else if (in_w && win_en && q != 0) e_idx = q;
    else                               e_idx = bg_val;
    exp_q.push_back({e_idx, e_blank, hs, vs});
    pix_q.push_back(y * 1000 + x);
    if (!vs) synced_m = 1'b1;
    @(posedge clk);
    #1;
    if (in_w) chk($sformatf("win_addr y%0d x%0d", y, x), 32'(win_addr), 32'(a));
    if (!vs) chk("win_addr_vs_clear", 32'(win_addr), 32'd0);
    if (exp_q.size() >= 3) begin
      e       = exp_q.pop_front();
      tag_pix = pix_q.pop_front();
      chk($sformatf("oIndex pix%0d", tag_pix), 32'(oIndex), 32'(e[10:3]));
      chk($sformatf("oBLANK_n pix%0d", tag_pix), 32'(oBLANK_n), 32'(e[2]));
      chk($sformatf("oHS pix%0d", tag_pix), 32'(oHS), 32'(e[1]));
      chk($sformatf("oVS pix%0d", tag_pix), 32'(oVS), 32'(e[0]));
    end
  endtask

  // One-cycle reset; outputs cleared and cursor back at centre (row 4, col 7).
  task automatic do_reset();
    iRST_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst oIndex", 32'(oIndex), 32'd0);
    chk("rst oBLANK_n", 32'(oBLANK_n), 32'd0);
    chk("rst oHS", 32'(oHS), 32'd0);
    chk("rst oVS", 32'(oVS), 32'd0);
    chk("rst win_addr", 32'(win_addr), 32'd0);
    chk("rst cursor_row", 32'(cursor_row), 32'd4);
    chk("rst cursor_col", 32'(cursor_col), 32'd7);
    iRST_n   = 1'b1;
    exp_q.delete();
    pix_q.delete();
    synced_m = 1'b0;
    cur_r    = 4;
    cur_c    = 7;
  endtask

  // Full frame with direction levels held; cursor checked after the vsync line.
  task automatic run_frame(input logic u, input logic d, input logic l, input logic r,
                           input int e_row, input int e_col,
                           input int rst_y = -1, input int rst_x = -1);
    logic act;
    logic hs;
    logic vs;
    up    = u;
    down  = d;
    left  = l;
    right = r;
    for (int ln = 0; ln < V_ACT + 2; ln++) begin
      for (int c = 0; c < H_ACT + H_BLK; c++) begin
        act = (ln >= 2) && (c < H_ACT);
        hs  = !((c == H_ACT + 1) || (c == H_ACT + 2));
        vs  = (ln != 0);
        if ((ln == rst_y + 2) && (c == rst_x)) do_reset();
        else drive_pix(act, hs, vs, c, ln - 2);
      end
      if (ln == 0) begin
        chk($sformatf("cursor_row udlr=%b%b%b%b", u, d, l, r), 32'(cursor_row), 32'(e_row));
        chk($sformatf("cursor_col udlr=%b%b%b%b", u, d, l, r), 32'(cursor_col), 32'(e_col));
        cur_r = e_row;
        cur_c = e_col;
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    iRST_n     = 1'b1;
    iBLANK_n   = 1'b0;
    iHS        = 1'b1;
    iVS        = 1'b1;
    up         = 1'b0;
    down       = 1'b0;
    left       = 1'b0;
    right      = 1'b0;
    win_en     = 1'b0;
    bg_index   = 8'h00;
    bg_val     = 8'h11;
    rom_transp = 1'b0;
    synced_m   = 1'b0;
    cur_r      = 4;
    cur_c      = 7;

    do_reset();

    // Window disabled: background everywhere, cursor hidden.
    win_en = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 7);

    // Window enabled, ROM = address: addr 0 is transparent, addr 1 at (2,5), 8 at (3,4),
    // 47 at (7,11); cursor block 255 over rows 4-5, cols 7-8.
    win_en = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 7);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 7);

    // Fully transparent window shows a different background.
    rom_transp = 1'b1;
    bg_val     = 8'h5A;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 7);
    rom_transp = 1'b0;
    bg_val     = 8'h11;

    // Right: 7 -> 9 -> 10 (clamped) -> 10; left&right together: no move.
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 4, 9);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 4, 10);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 4, 10);
    run_frame(1'b0, 1'b0, 1'b1, 1'b1, 4, 10);

    // Up: 4 -> 2 -> 2 (top edge); up&down together: no move.
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 2, 10);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 2, 10);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 2, 10);

    // Diagonal down-left: row 4, col 8.
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 4, 8);

    // Down to row 6, then a reset mid-line at y=3 x=8 recentres and blanks the rest.
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 6, 8, 3, 8);

    // The following frame matches an undisturbed frame with the cursor centred.
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 7);

    // Drain the pipeline.
    for (int i = 0; i < 3; i++) drive_pix(1'b0, 1'b1, 1'b1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
